// File: rtl/pll_tune_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_tune_sequencer
// Description : Drives a PLL reconfiguration controller through one retune.
//               Five counter parameters (N, M, C0 hi/lo/odd) are written one
//               at a time. A reconfig strobe follows. Lock is then qualified
//               with a timeout, and the PLL is reset and retried a bounded
//               number of times.
// Ports       : clk, rst_n (async, active low)
//               tune_req, tune_m, tune_n, tune_c0_hi/lo/odd -- request + values
//               tune_busy, tune_done (pulse), tune_err (sticky)  -- status
//               counter_type, counter_param, data_in, write_param, reconfig,
//               reconfig_busy                                    -- reconfig ctrl
//               pll_lock, pll_areset                             -- PLL
// Revision    : 1.0 -- initial release
// ============================================================================
module pll_tune_sequencer #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_QUAL    = 4,
    parameter int RESET_CYCLES = 16,
    parameter int MAX_RETRY    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tune_req,
    input  logic [8:0] tune_m,
    input  logic [8:0] tune_n,
    input  logic [7:0] tune_c0_hi,
    input  logic [7:0] tune_c0_lo,
    input  logic       tune_c0_odd,
    output logic       tune_busy,
    output logic       tune_done,
    output logic       tune_err,
    output logic [3:0] counter_type,
    output logic [2:0] counter_param,
    output logic [8:0] data_in,
    output logic       write_param,
    output logic       reconfig,
    input  logic       reconfig_busy,
    input  logic       pll_lock,
    output logic       pll_areset
);

    // Counter widths cover their maximum value; never narrower than one bit.
    localparam int TO_W  = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam int LQ_W  = (LOCK_QUAL    < 1) ? 1 : $clog2(LOCK_QUAL + 1);
    localparam int RST_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY    < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TO_W-1:0]  c_TO_MAX   = TO_W'(LOCK_TIMEOUT);
    localparam logic [LQ_W-1:0]  c_QUAL_MAX = LQ_W'(LOCK_QUAL);
    localparam logic [RST_W-1:0] c_RST_MAX  = RST_W'(RESET_CYCLES);
    localparam logic [RST_W-1:0] c_RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [RTY_W-1:0] c_RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [2:0]       c_IDX_LAST = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LATCH  = 4'd1,
        S_SETUP  = 4'd2,
        S_WRITE  = 4'd3,
        S_WBLANK = 4'd4,
        S_WWAIT  = 4'd5,
        S_RCFG   = 4'd6,
        S_RBLANK = 4'd7,
        S_RWAIT  = 4'd8,
        S_LOCK   = 4'd9,
        S_PRESET = 4'd10,
        S_DONE   = 4'd11,
        S_FAIL   = 4'd12
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [8:0]         r_m, r_n;
    logic [7:0]         r_hi, r_lo;
    logic               r_odd;
    logic [2:0]         r_idx;
    logic [LQ_W-1:0]    r_lock_cnt, w_lock_nxt;
    logic [TO_W-1:0]    r_to_cnt, w_to_nxt;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [RTY_W-1:0]   r_retry;
    logic               r_err;
    logic               w_lock_hit, w_to_hit;

    // Saturating next values for the lock-qualification counters. The lock
    // run restarts whenever pll_lock drops.
    always_comb begin
        w_lock_nxt = '0;
        if (pll_lock) begin
            w_lock_nxt = (r_lock_cnt == c_QUAL_MAX) ? r_lock_cnt : r_lock_cnt + 1'b1;
        end
        w_to_nxt   = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
        w_lock_hit = (w_lock_nxt == c_QUAL_MAX);
        w_to_hit   = (w_to_nxt == c_TO_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (tune_req && !reconfig_busy) w_next = S_LATCH;
            S_LATCH:  w_next = (tune_m == '0 || tune_n == '0) ? S_FAIL : S_SETUP;
            S_SETUP:  w_next = S_WRITE;
            S_WRITE:  w_next = S_WBLANK;
            S_WBLANK: w_next = S_WWAIT;
            S_WWAIT:  if (!reconfig_busy) w_next = (r_idx == c_IDX_LAST) ? S_RCFG : S_SETUP;
            S_RCFG:   w_next = S_RBLANK;
            S_RBLANK: w_next = S_RWAIT;
            S_RWAIT:  if (!reconfig_busy) w_next = S_LOCK;
            // Lock qualification takes priority over a coincident timeout.
            S_LOCK: begin
                if (w_lock_hit) begin
                    w_next = S_DONE;
                end else if (w_to_hit) begin
                    w_next = (r_retry < c_RTY_MAX) ? S_PRESET : S_FAIL;
                end
            end
            S_PRESET: if (r_rst_cnt == c_RST_LAST) w_next = S_LOCK;
            S_DONE:   w_next = S_IDLE;
            S_FAIL:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: latched request, write index, counters and the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m        <= '0;
            r_n        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_odd      <= 1'b0;
            r_idx      <= '0;
            r_lock_cnt <= '0;
            r_to_cnt   <= '0;
            r_rst_cnt  <= '0;
            r_retry    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_next == S_LATCH) begin
                r_err <= 1'b0;
            end
            if (r_state == S_FAIL) begin
                r_err <= 1'b1;
            end
            if (r_state == S_LATCH) begin
                r_m     <= tune_m;
                r_n     <= tune_n;
                r_hi    <= tune_c0_hi;
                r_lo    <= tune_c0_lo;
                r_odd   <= tune_c0_odd;
                r_idx   <= '0;
                r_retry <= '0;
            end
            if (r_state == S_WWAIT && w_next == S_SETUP) begin
                r_idx <= r_idx + 1'b1;
            end
            // Counters clear on every LOCK entry, including after a PLL reset.
            if (r_state == S_LOCK) begin
                r_lock_cnt <= w_lock_nxt;
                r_to_cnt   <= w_to_nxt;
            end else begin
                r_lock_cnt <= '0;
                r_to_cnt   <= '0;
            end
            if (r_state == S_PRESET) begin
                r_rst_cnt <= (r_rst_cnt == c_RST_MAX) ? r_rst_cnt : r_rst_cnt + 1'b1;
            end else begin
                r_rst_cnt <= '0;
            end
            if (r_state == S_LOCK && w_next == S_PRESET && r_retry != c_RTY_MAX) begin
                r_retry <= r_retry + 1'b1;
            end
        end
    end

    // Outputs decode from registered state only. The address/data bus holds
    // the indexed table entry from SETUP until WWAIT exits, and is 0 elsewhere.
    always_comb begin
        counter_type  = '0;
        counter_param = '0;
        data_in       = '0;
        if (r_state == S_SETUP || r_state == S_WRITE ||
            r_state == S_WBLANK || r_state == S_WWAIT) begin
            case (r_idx)
                3'd0:    begin counter_type = 4'd0; counter_param = 3'd7; data_in = r_n; end
                3'd1:    begin counter_type = 4'd1; counter_param = 3'd7; data_in = r_m; end
                3'd2:    begin counter_type = 4'd4; counter_param = 3'd0; data_in = {1'b0, r_hi}; end
                3'd3:    begin counter_type = 4'd4; counter_param = 3'd1; data_in = {1'b0, r_lo}; end
                default: begin counter_type = 4'd4; counter_param = 3'd5; data_in = {8'd0, r_odd}; end
            endcase
        end
        tune_busy   = (r_state != S_IDLE);
        tune_done   = (r_state == S_DONE);
        tune_err    = r_err;
        write_param = (r_state == S_WRITE);
        reconfig    = (r_state == S_RCFG);
        pll_areset  = (r_state == S_PRESET);
    end

endmodule
`default_nettype wire
